// File: rtl/cmp_word_sequencer_if.sv
// Handshake bundle between the digit-result producer (master) and cmp_word_sequencer (slave).
interface cmp_word_sequencer_if;
  logic       start;
  logic [2:0] f_in;
  logic       f_valid;
  logic       f_ready;
  logic       busy;
  logic       done;
  logic [2:0] result;
  logic       error;

  modport master (
    output start, f_in, f_valid,
    input  f_ready, busy, done, result, error
  );

  modport slave (
    input  start, f_in, f_valid,
    output f_ready, busy, done, result, error
  );
endinterface

// File: rtl/cmp_word_sequencer.sv
// Resolves a 2*DIGITS-bit magnitude relation from serial {gt,eq,lt} digit results, MSB first.
// Optional macro CMP_EARLY_EXIT_EN: the word finishes on the first deciding digit.
module cmp_word_sequencer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cmp_word_sequencer_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for start; last result/error held
  // ACCUM | accepting digits, MSB pair first
  // DONE  | single cycle with done high; start here restarts
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned      CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  localparam logic [2:0] REL_GT   = 3'b100;
  localparam logic [2:0] REL_EQ   = 3'b010;
  localparam logic [2:0] REL_LT   = 3'b001;
  localparam logic [2:0] REL_NONE = 3'b000;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic [2:0]       result_q, result_d;
  logic             error_q, error_d;
  logic             done_q, done_d;

  logic accept;
  logic digit_decides;
  logic digit_legal;
  logic last_digit;
  logic finish;

  assign accept        = bus.f_valid && (state_q == S_ACCUM);
  assign digit_decides = (bus.f_in == REL_GT) || (bus.f_in == REL_LT);
  assign digit_legal   = digit_decides || (bus.f_in == REL_EQ);
  assign last_digit    = (cnt_q == CNT_LAST);

`ifdef CMP_EARLY_EXIT_EN
  // Remaining digits are left for the upstream sequencer to drop on done.
  assign finish = last_digit || !digit_legal || (!decided_q && digit_decides);
`else
  assign finish = last_digit || !digit_legal;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    result_d  = result_q;
    error_d   = error_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_ACCUM;
          cnt_d     = '0;
          decided_d = 1'b0;
          result_d  = REL_EQ;
          error_d   = 1'b0;
        end else begin
          // result/error are deliberately kept until the next accepted start
          state_d = S_IDLE;
        end
      end

      S_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (!digit_legal) begin
            error_d  = 1'b1;
            result_d = REL_NONE;
          end else if (!decided_q && digit_decides) begin
            result_d  = bus.f_in;
            decided_d = 1'b1;
          end
          if (finish) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      result_q  <= REL_NONE;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      result_q  <= result_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

  assign bus.f_ready = (state_q == S_ACCUM);
  assign bus.busy    = (state_q == S_ACCUM);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.error   = error_q;

endmodule

// File: tb/tb_cmp_word_sequencer.sv
// Randomized bench: words A,B are compared as whole integers and fed as serial 2-bit digit results.
module tb_cmp_word_sequencer;
  localparam int DIGITS = 4;
  localparam int W      = 2 * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cmp_word_sequencer_if bus ();

  cmp_word_sequencer #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] ill_tab [5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] slice_rel(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
    logic [1:0] sa, sb;
    sa = a[2*i +: 2];
    sb = b[2*i +: 2];
    if (sa > sb)       return 3'b100;
    else if (sa == sb) return 3'b010;
    else               return 3'b001;
  endfunction

  // stall_mode: 0 none, 1 two idle cycles between digits, 2 random 0..2 idle cycles
  // poke_start: drive start during ACCUM (must be ignored); chain: return in the done cycle
  task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input int ill_pos,
                          input logic [2:0] ill_code, input int stall_mode, input bit poke_start,
                          input bit chain);
    logic [2:0] digs [DIGITS];
    logic [2:0] res_exp;
    logic       err_exp;
    int first_diff, k_exp, acc, stalls, cyc, pend;
    bit took;

    first_diff = DIGITS;
    for (int i = 0; i < DIGITS; i++) begin
      digs[i] = slice_rel(a, b, DIGITS - 1 - i);
      if (digs[i] != 3'b010 && first_diff == DIGITS) first_diff = i;
    end
    res_exp = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
    err_exp = 1'b0;
`ifdef CMP_EARLY_EXIT_EN
    k_exp = (first_diff < DIGITS) ? first_diff + 1 : DIGITS;
`else
    k_exp = DIGITS;
`endif
    if (ill_pos >= 0 && ill_pos < k_exp) begin
      digs[ill_pos] = ill_code;
      k_exp   = ill_pos + 1;
      res_exp = 3'b000;
      err_exp = 1'b1;
    end

    bus.start   = 1'b1;
    bus.f_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    chk("accum_busy", 32'(bus.busy), 32'd1);
    chk("provisional_eq", 32'(bus.result), 32'b010);
    chk("error_cleared", 32'(bus.error), 32'd0);

    acc    = 0;
    stalls = 0;
    pend   = (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int t = 0; t < 200 && acc < k_exp; t++) begin
      chk("ready_in_accum", 32'(bus.f_ready), 32'd1);
      if (pend > 0) begin
        bus.f_valid = 1'b0;
        bus.f_in    = 3'($urandom_range(0, 7));
        pend--;
        stalls++;
      end else begin
        bus.f_valid = 1'b1;
        bus.f_in    = digs[acc];
      end
      bus.start = poke_start ? 1'b1 : ((stall_mode == 2) && ($urandom_range(0, 3) == 0));
      took = bus.f_valid && bus.f_ready;
      tick();
      cyc++;
      if (took) begin
        acc++;
        if (stall_mode == 1)      pend = 2;
        else if (stall_mode == 2) pend = int'($urandom_range(0, 2));
      end
      chk("done_pulse", 32'(bus.done), 32'(acc == k_exp));
    end
    bus.start   = 1'b0;
    bus.f_valid = 1'b0;

    chk("digits_consumed", 32'(acc), 32'(k_exp));
    chk("done_latency", 32'(cyc), 32'(1 + k_exp + stalls));
    chk("result", 32'(bus.result), 32'(res_exp));
    chk("error", 32'(bus.error), 32'(err_exp));

    if (!chain) begin
      tick();
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("ready_after_done", 32'(bus.f_ready), 32'd0);
      chk("result_held", 32'(bus.result), 32'(res_exp));
      chk("error_held", 32'(bus.error), 32'(err_exp));
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    int ip;

    ill_tab[0] = 3'b000; ill_tab[1] = 3'b011; ill_tab[2] = 3'b101;
    ill_tab[3] = 3'b110; ill_tab[4] = 3'b111;

    bus.start   = 1'b0;
    bus.f_valid = 1'b0;
    bus.f_in    = 3'b000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.f_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // directed words
    run_word(8'h5A, 8'h5A, -1, 3'b000, 0, 1'b0, 1'b0);
    run_word(8'b10_00_00_00, 8'b01_11_11_11, -1, 3'b000, 0, 1'b0, 1'b0);
    run_word(8'b00_00_01_11, 8'b00_00_10_00, -1, 3'b000, 1, 1'b0, 1'b0);
    run_word(8'h00, 8'h00, 1, 3'b110, 0, 1'b1, 1'b0);
    run_word(8'hC3, 8'h3C, -1, 3'b000, 0, 1'b0, 1'b1);
    run_word(8'h11, 8'h12, -1, 3'b000, 0, 1'b0, 1'b0);

    // reset asserted mid-word
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.f_valid = 1'b1;
    bus.f_in    = 3'b010;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_ready", 32'(bus.f_ready), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    bus.f_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_word(8'h27, 8'h27, -1, 3'b000, 0, 1'b0, 1'b0);

    // randomized words
    for (int n = 0; n < 150; n++) begin
      a = W'($urandom);
      b = a;
      if ($urandom_range(0, 3) != 0) b[2*$urandom_range(0, DIGITS-1) +: 2] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b = W'($urandom);
      ip = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DIGITS-1)) : -1;
      run_word(a, b, ip, ill_tab[$urandom_range(0, 4)], 2, 1'b0, 1'($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cmp_word_sequencer.md
# cmp_word_sequencer

Serial word comparator stage that sits directly downstream of the 2-bit comparator. It consumes one `{gt, eq, lt}` digit result per handshake, MSB digit pair first, over `DIGITS` digit pairs. It resolves the full-word magnitude relation and presents it as a registered one-hot result with a done pulse. It lets the team compare words of `2*DIGITS` bits with a single 2-bit comparator instance.

## Interface
- `DIGITS`, default 4: number of 2-bit digit pairs per word (word width = 2*DIGITS). Legal range is 1..64.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new word comparison; honoured only in IDLE or DONE.
- `f_in`  in  3  digit result from the comparator: [2]=A>B, [1]=A==B, [0]=A<B. Must be one-hot.
- `f_valid`  in  1  `f_in` is valid this cycle.
- `f_ready`  out  1  stage accepts a digit this cycle; high only in ACCUM.
- `busy`  out  1  high in ACCUM.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `result`  out  3  word relation, same encoding as `f_in`; held until the next accepted `start`.
- `error`  out  1  a non-one-hot `f_in` was accepted during this word; held with `result`.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `start`=1 moves to ACCUM next cycle.
  - Clear the digit counter to 0, `decided`=0, `result`=3'b010 (provisional equal), `error`=0.
- ACCUM:
  - A digit is accepted when `f_valid && f_ready`.
  - On each accepted digit, the counter increments.
  - If `decided`=0 and `f_in` is 3'b100 or 3'b001: `result`<=`f_in`, `decided`<=1.
  - If `decided`=0 and `f_in` is 3'b010: `result` is unchanged.
  - Digits accepted after `decided`=1 do not alter `result`.
  - If `f_in` is not one of 3'b100, 3'b010 or 3'b001: `error`<=1, `result`<=3'b000, go to DONE immediately.
  - The last digit is the one accepted with counter == DIGITS-1; accepting it goes to DONE.
  - `f_valid`=0 holds the state; there is no timeout.
- DONE:
  - `done`=1 for exactly the entry cycle.
  - `result` and `error` stay stable.
  - `start`=1 restarts: same clears as IDLE, then ACCUM next cycle.
  - With no `start`, return to IDLE after one cycle. `result` and `error` are retained.
- `start` while in ACCUM is ignored; the word in progress continues.
- An all-equal word ends with `result`=3'b010.
- Counter width is clog2(DIGITS), with a minimum of 1 bit.

## Timing
- Reset (async assert, sync release):
  - State = IDLE.
  - `result`=3'b000, `error`=0, `done`=0, `busy`=0, `f_ready`=0.
  - Counter = 0, `decided`=0.
- `f_ready`/`busy` rise in the cycle after `start` is sampled.
- Back-to-back `f_valid`=1 gives one digit per cycle.
- Latency from `start` to `done` is DIGITS+1 cycles minimum, then `done` pulses. Stalls add cycles one-for-one.
- Outputs are registered: `result` updates the cycle after the accepting edge.
- Reset asserted mid-ACCUM aborts at once; the partial result is discarded.
- With DIGITS=1, the first accepted digit ends the word.

## Configuration
- `CMP_EARLY_EXIT_EN` defined:
  - In ACCUM, accepting a digit that sets `decided` (3'b100 or 3'b001) goes straight to DONE.
  - The remaining digits are not consumed. The upstream sequencer must discard them on `done`.
- `CMP_EARLY_EXIT_EN` undefined:
  - All DIGITS digits are always consumed.
  - Latency is fixed for a stall-free stream.

## Test plan
- Reset:
  - Assert `rst_n`=0 mid-ACCUM after 2 digits -> async clear.
  - `result`=000, `f_ready`=0.
  - After release, `start` begins a fresh word with `result` provisional 010.
- Equal word: DIGITS=4, digits 010,010,010,010 back-to-back -> `done` pulse 5 cycles after `start`, `result`=010, `error`=0.
- MSB decides:
  - Digits 100,001,001,001 -> `result`=100.
  - Early-exit undefined: all 4 digits consumed.
  - Early-exit defined: `done` after the first digit, `f_ready` low thereafter.
- Late decision with stalls: digits 010,010,001,100 with `f_valid` low for 2 cycles between digits -> `result`=001, `done` on cycle 11 after `start`.
- Illegal digit: second digit 110 -> `error`=1, `result`=000, immediate DONE, `start` ignored while in ACCUM.
- Restart from DONE: `start` high in the `done` cycle -> ACCUM next cycle, `result` cleared to 010, second word resolves independently.
